// File: rtl/tbuf_arb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
// Optional parking mode is selected with TBUF_ARB_PARK_EN.
package tbuf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    DEAD = 2'd2
  } state_e;

  localparam int MIN_N = 2;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the value v itself
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v + 1) : 1;
  endfunction

endpackage

// File: rtl/tbuf_arb_rr_pick.sv
// Rotating-priority picker: first set req bit at index >= ptr,
// wrapping around; one-hot result plus a valid flag.
module tbuf_arb_rr_pick
  import tbuf_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic [IDX_W-1:0] j;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[j]) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with break-before-make
// dead cycles. Define TBUF_ARB_PARK_EN to park EN on the last owner.
module tbuf_bus_arbiter
  import tbuf_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DEAD_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] en,
  output logic [N-1:0] en_bar,
  output logic         bus_idle
);

  localparam int IDX_W  = idx_w(N);
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  localparam int DEAD_W = cnt_w(DEAD_CYC);

  state_e state, state_nx;

  logic [IDX_W-1:0]  ptr, ptr_nx;
  logic [IDX_W-1:0]  own_idx, own_nx;
  logic [IDX_W-1:0]  pick_idx, nxt_idx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [DEAD_W-1:0] dead_cnt, dead_nx;

  logic [N-1:0] pick, owner_oh;
  logic [N-1:0] gnt_d, en_d;
  logic         pick_vld;
  logic         oth_req, hold_max;
  logic         rel, dead_last;

  function automatic logic [N-1:0] dec(
    input logic [IDX_W-1:0] i
  );
    dec    = '0;
    dec[i] = 1'b1;
  endfunction

  tbuf_arb_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign owner_oh = dec(own_idx);
  assign oth_req  = |(req & ~owner_oh);
  assign nxt_idx  = (own_idx == IDX_W'(N - 1))
                  ? '0 : own_idx + IDX_W'(1);

  // >= keeps preemption working when waiters show up after saturation
  assign hold_max = (MAX_HOLD != 0)
                 && (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
  assign rel       = !req[own_idx] || (hold_max && oth_req);
  assign dead_last = (dead_cnt == DEAD_W'(DEAD_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      own_idx  <= '0;
      hold_cnt <= '0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      own_idx  <= own_nx;
      hold_cnt <= hold_nx;
      dead_cnt <= dead_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    own_nx   = own_idx;
    hold_nx  = hold_cnt;
    dead_nx  = dead_cnt;
    unique case (state)
      IDLE: begin
`ifdef TBUF_ARB_PARK_EN
        if (|en && req[own_idx]) begin
          state_nx = OWN;
          hold_nx  = '0;
        end else if (|en && |req) begin
          state_nx = DEAD;
          dead_nx  = '0;
        end else
`endif
        if (pick_vld) begin
          state_nx = OWN;
          own_nx   = pick_idx;
          hold_nx  = '0;
        end
      end
      OWN: begin
        if (rel) begin
          ptr_nx = nxt_idx;
`ifdef TBUF_ARB_PARK_EN
          if (!oth_req) state_nx = IDLE;
          else
`endif
          begin
            state_nx = DEAD;
            dead_nx  = '0;
          end
        end else if (MAX_HOLD != 0
                  && hold_cnt != HOLD_W'(MAX_HOLD)) begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      DEAD: begin
        if (!dead_last) begin
          dead_nx = dead_cnt + DEAD_W'(1);
        end else if (pick_vld) begin
          state_nx = OWN;
          own_nx   = pick_idx;
          hold_nx  = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    en_d  = '0;
    unique case (state_nx)
      OWN: begin
        gnt_d = dec(own_nx);
        en_d  = dec(own_nx);
      end
`ifdef TBUF_ARB_PARK_EN
      IDLE: en_d = en;
`endif
      default: ;
    endcase
  end

  // en_bar is the inverted flop output, so it is all-ones in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      en       <= '0;
      bus_idle <= 1'b1;
    end else begin
      gnt      <= gnt_d;
      en       <= en_d;
      bus_idle <= ~|en_d;
    end
  end

  assign en_bar = ~en;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Self-checking bench for tbuf_bus_arbiter (N=4, DEAD_CYC=1,
// MAX_HOLD=4); follows TBUF_ARB_PARK_EN when defined.
module tb_tbuf_bus_arbiter;

  localparam int N  = 4;
  localparam int DC = 1;
  localparam int MH = 4;
`ifdef TBUF_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt, en, en_bar;
  logic         bus_idle;

  int tests = 0;
  int fails = 0;

  // Reference: who drives, who is parked, dead cycles left
  int m_owner, m_park, m_gap, m_ptr, m_run;

  always #5 clk = ~clk;

  tbuf_bus_arbiter #(
    .N        (N),
    .DEAD_CYC (DC),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .en       (en),
    .en_bar   (en_bar),
    .bus_idle (bus_idle)
  );

  function automatic logic [N-1:0] oh(input int i);
    if (i < 0) return '0;
    return N'(1) << i;
  endfunction

  function automatic bit has(input logic [N-1:0] r, input int i);
    return |(r & oh(i));
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (has(r, (p + i) % N)) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_park  = -1;
    m_gap   = 0;
    m_ptr   = 0;
    m_run   = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] oth;
    if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_owner = rr(r, m_ptr);
        m_run   = 0;
      end
    end else if (m_owner >= 0) begin
      m_run++;
      oth = r & ~oh(m_owner);
      if (!has(r, m_owner) || (m_run >= MH && oth != 0)) begin
        m_ptr = (m_owner + 1) % N;
        if (PARK && oth == 0) m_park = m_owner;
        else m_gap = DC;
        m_owner = -1;
      end
    end else if (m_park >= 0) begin
      if (has(r, m_park)) begin
        m_owner = m_park;
        m_park  = -1;
        m_run   = 0;
      end else if (r != 0) begin
        m_park = -1;
        m_gap  = DC;
      end
    end else begin
      m_owner = rr(r, m_ptr);
      m_run   = 0;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [N-1:0] ee, eg;
    eg = oh(m_owner);
    ee = (m_owner >= 0) ? eg : oh(m_park);
    chk({tag, ".en"}, en, ee);
    chk({tag, ".en_bar"}, en_bar, ~ee);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".bus_idle"}, N'(bus_idle), N'(ee == '0));
    chk({tag, ".onehot0"}, N'($onehot0(en)), N'(1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(req);
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(input string tag, input logic [N-1:0] r,
                     input int n);
    req = r;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Async pulse started between edges, checked before the next edge
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check(tag);
    chk({tag, ".lit_en"}, en, 4'b0000);
    chk({tag, ".lit_en_bar"}, en_bar, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    model_reset();
    @(negedge clk);
    check("reset");
    rst = 1'b0;
    step("idle");

    req = 4'b0100;
    step("t2");
    chk("t2.lit_en", en, 4'b0100);
    chk("t2.lit_gnt", gnt, 4'b0100);
    chk("t2.lit_en_bar", en_bar, 4'b1011);
    chk("t2.lit_bus_idle", N'(bus_idle), N'(0));
    step("t2b");
    rst_pulse("t1");

    run("t3a", 4'b0011, 3);
    run("t3b", 4'b0010, 4);
    run("t3c", 4'b0000, 3);

    run("t4", 4'b1111, 26);
    run("t4z", 4'b0000, 3);

    run("t5", 4'b0100, 22);
    run("t5z", 4'b0000, 3);
    rst_pulse("t6rst");

    run("t6a", 4'b0010, 3);
    run("t6b", 4'b0000, 3);
    run("t6c", 4'b0010, 2);
    run("t6d", 4'b0000, 2);
    run("t6e", 4'b1000, 4);
    run("t6f", 4'b0000, 3);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      step("rand");
      if ($urandom_range(59) == 0) rst_pulse("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
